stack_memory: RTL and testbench

Parametrised data memory with an integrated hardware stack. It is the next generation of the processor's 8-bit RAM, which offers push/pop ports. Random read/write and push/pop share one storage array, and the stack pointer is kept inside the block. The block adds configurable width, address space and stack depth, full/empty status, sticky overflow/underflow errors and a single-cycle replace-top operation. It sits between the control unit (command strobes) and the datapath (bus data, address and stack-pointer display).

---
 rtl/stack_mem_pkg.sv | 30 +++
 rtl/ram_sp.sv | 36 +++
 rtl/stack_memory.sv | 128 ++++++++++++
 tb/tb_stack_memory.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_mem_pkg.sv
// Shared defaults and the command set for stack_memory.
// decode_cmd resolves simultaneous strobes into one command by priority.
package stack_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_READ,
        CMD_WRITE,
        CMD_PUSH,
        CMD_POP,
        CMD_REPLACE
    } cmd_e;

    // Stack strobes outrank random access; write outranks read.
    function automatic cmd_e decode_cmd(input logic rd, input logic wr,
                                        input logic psh, input logic pp);
        cmd_e c;
        if (psh && pp)  c = CMD_REPLACE;
        else if (psh)   c = CMD_PUSH;
        else if (pp)    c = CMD_POP;
        else if (wr)    c = CMD_WRITE;
        else if (rd)    c = CMD_READ;
        else            c = CMD_IDLE;
        return c;
    endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM with a registered read port.
// A read and write to the same address in one cycle returns the old word.
module ram_sp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The read register only moves on a read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_memory.sv
// Data memory with an integrated downward-growing hardware stack sharing one array.
// Commands are decoded by priority, then qualified against full/empty.
module stack_memory
    import stack_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_TOP   = 2**ADDR_W - 1,
    parameter int STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    output logic [ADDR_W-1:0] sp,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] TOP_A   = ADDR_W'(STACK_TOP);
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(STACK_DEPTH);

    logic [ADDR_W-1:0] sp_q, sp_d, sp_plus1;
    logic [ADDR_W:0]   count;
    logic              valid_q, ovf_q, unf_q;
    logic              ovf_set, unf_set;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    cmd_e              cmd_raw, cmd;

    assign sp_plus1 = sp_q + ADDR_W'(1);
    assign count    = {1'b0, TOP_A} - {1'b0, sp_q};
    assign full     = (count == DEPTH_A);
    assign empty    = (count == '0);
    assign cmd_raw  = decode_cmd(read, write, push, pop);

    // Illegal stack operations collapse to IDLE and only raise their error flag.
    always_comb begin
        cmd     = cmd_raw;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (cmd_raw)
            CMD_PUSH: if (full) begin
                cmd     = CMD_IDLE;
                ovf_set = 1'b1;
            end
            CMD_POP, CMD_REPLACE: if (empty) begin
                cmd     = CMD_IDLE;
                unf_set = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = address;
        sp_d     = sp_q;
        case (cmd)
            CMD_READ:  ram_re = 1'b1;
            CMD_WRITE: ram_we = 1'b1;
            CMD_PUSH: begin
                ram_we   = 1'b1;
                ram_addr = sp_q;
                sp_d     = sp_q - ADDR_W'(1);
            end
            CMD_POP: begin
                ram_re   = 1'b1;
                ram_addr = sp_plus1;
                sp_d     = sp_plus1;
            end
            CMD_REPLACE: begin
                ram_re   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = sp_plus1;
            end
            default: ;
        endcase
        // Reset cancels whatever command arrives with it.
        if (rst) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= TOP_A;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            valid_q <= ram_re;
            ovf_q   <= ovf_set | (ovf_q & ~err_clr);
            unf_q   <= unf_set | (unf_q & ~err_clr);
        end
    end

    ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (data_in),
        .rdata_o (out)
    );

    assign valid     = valid_q;
    assign sp        = sp_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_memory.sv
// Self-checking bench for stack_memory: directed scenarios plus random traffic
// scored against an array/stack-pointer reference model.
module tb_stack_memory;

    localparam int TOP   = 255;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, read, write, push, pop, err_clr;
    logic [7:0] address, data_in, out, sp;
    logic       valid, full, empty, overflow, underflow;

    always #5 clk = ~clk;

    stack_memory #(
        .DATA_W      (8),
        .ADDR_W      (8),
        .STACK_TOP   (TOP),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .read      (read),
        .write     (write),
        .push      (push),
        .pop       (pop),
        .address   (address),
        .data_in   (data_in),
        .err_clr   (err_clr),
        .out       (out),
        .valid     (valid),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Reference model: the array, the stack pointer and the observable registers.
    logic [7:0] m_mem [256];
    int         m_sp;
    logic [7:0] m_out;
    logic       m_ov, m_uf;
    logic [7:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void emit(input logic [7:0] v);
        m_out = v;
        exp_q.push_back(v);
    endfunction

    function automatic void model_step(input bit r, input bit p_push, input bit p_pop,
                                       input bit p_wr, input bit p_rd, input bit clr,
                                       input logic [7:0] a, input logic [7:0] d);
        int cnt;
        if (r) begin
            m_sp  = TOP;
            m_ov  = 1'b0;
            m_uf  = 1'b0;
            m_out = 8'h00;
            return;
        end
        cnt = TOP - m_sp;
        if (clr) begin
            m_ov = 1'b0;
            m_uf = 1'b0;
        end
        if (p_push && p_pop) begin
            if (cnt == 0) m_uf = 1'b1;
            else begin
                emit(m_mem[m_sp + 1]);
                m_mem[m_sp + 1] = d;
            end
        end else if (p_push) begin
            if (cnt == DEPTH) m_ov = 1'b1;
            else begin
                m_mem[m_sp] = d;
                m_sp = m_sp - 1;
            end
        end else if (p_pop) begin
            if (cnt == 0) m_uf = 1'b1;
            else begin
                emit(m_mem[m_sp + 1]);
                m_sp = m_sp + 1;
            end
        end else if (p_wr) begin
            m_mem[a] = d;
        end else if (p_rd) begin
            emit(m_mem[a]);
        end
    endfunction

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic cycle(input bit r, input bit p_push, input bit p_pop, input bit p_wr,
                         input bit p_rd, input bit clr, input logic [7:0] a, input logic [7:0] d);
        rst = r; push = p_push; pop = p_pop; write = p_wr; read = p_rd;
        err_clr = clr; address = a; data_in = d;
        @(posedge clk);
        model_step(r, p_push, p_pop, p_wr, p_rd, clr, a, d);
        #1;
        rst = 1'b0; push = 1'b0; pop = 1'b0; write = 1'b0; read = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] d);  cycle(0, 1, 0, 0, 0, 0, 8'h00, d); endtask
    task automatic do_pop();                      cycle(0, 0, 1, 0, 0, 0, 8'h00, 8'h00); endtask
    task automatic do_idle();                     cycle(0, 0, 0, 0, 0, 0, 8'h00, 8'h00); endtask

    // Monitor: pops the scoreboard on every valid pulse and tracks status outputs.
    always @(negedge clk) begin
        if (mon_on) begin
            if (valid) begin
                if (exp_q.size() == 0) check("spurious_valid", valid, 1'b0);
                else check("read_data", out, exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                check("missing_valid", valid, 1'b1);
                exp_q.delete();
            end
            check("out_hold", out, m_out);
            check("sp", sp, m_sp);
            check("full", full, (TOP - m_sp) == DEPTH);
            check("empty", empty, m_sp == TOP);
            check("overflow", overflow, m_ov);
            check("underflow", underflow, m_uf);
        end
    end

    initial begin
        rst = 1'b1; read = 1'b0; write = 1'b0; push = 1'b0; pop = 1'b0;
        err_clr = 1'b0; address = 8'h00; data_in = 8'h00;
        cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        cycle(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        mon_on = 1'b1;
        check("rst_out", out, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_empty", empty, 1'b1);

        // Give every word a known value so random reads are predictable.
        for (int i = 0; i < 256; i++) cycle(0, 0, 0, 1, 0, 0, 8'(i), 8'($urandom_range(0, 255)));

        // Write then read back.
        cycle(0, 0, 0, 1, 0, 0, 8'h10, 8'h5A);
        cycle(0, 0, 0, 0, 1, 0, 8'h10, 8'h00);
        check("rd_out", out, 8'h5A);
        check("rd_valid", valid, 1'b1);
        check("rd_sp", sp, 8'hFF);

        // Read+write together: write wins, no valid.
        cycle(0, 0, 0, 1, 1, 0, 8'h20, 8'h77);
        check("rdwr_valid", valid, 1'b0);
        check("rdwr_out", out, 8'h5A);

        // LIFO order.
        do_push(8'h11); check("p1_sp", sp, 8'hFE);
        do_push(8'h22); check("p2_sp", sp, 8'hFD);
        do_push(8'h33); check("p3_sp", sp, 8'hFC);
        do_pop(); check("pop1_out", out, 8'h33);
        do_pop(); check("pop2_out", out, 8'h22);
        do_pop(); check("pop3_out", out, 8'h11);
        check("lifo_sp", sp, 8'hFF);
        check("lifo_empty", empty, 1'b1);

        // Overflow at depth 4.
        for (int i = 0; i < 4; i++) do_push(8'hA1 + 8'(i));
        check("ovf_full", full, 1'b1);
        do_push(8'hA5);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_sp", sp, 8'hFB);
        for (int i = 0; i < 4; i++) begin
            do_pop();
            check("ovf_pop", out, 8'hA4 - 8'(i));
        end
        cycle(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("ovf_clr", overflow, 1'b0);

        // Underflow.
        do_pop();
        check("unf_flag", underflow, 1'b1);
        check("unf_valid", valid, 1'b0);
        check("unf_out", out, 8'hA1);
        cycle(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("unf_clr", underflow, 1'b0);
        cycle(0, 1, 1, 0, 0, 0, 8'h00, 8'hCC);
        check("unf_rep", underflow, 1'b1);
        check("unf_rep_sp", sp, 8'hFF);
        // Error in the same cycle as err_clr: set wins.
        cycle(0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
        check("unf_setwins", underflow, 1'b1);
        cycle(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);

        // Replace top.
        do_push(8'hAA);
        cycle(0, 1, 1, 0, 0, 0, 8'h00, 8'hBB);
        check("rep_out", out, 8'hAA);
        check("rep_sp", sp, 8'hFE);
        do_pop();
        check("rep_pop", out, 8'hBB);
        check("rep_sp2", sp, 8'hFF);

        // Reset mid-stack cancels a simultaneous push.
        do_push(8'h01);
        do_push(8'h02);
        cycle(1, 1, 0, 0, 0, 0, 8'h00, 8'h03);
        check("rst_sp", sp, 8'hFF);
        check("rst_empty2", empty, 1'b1);
        check("rst_out2", out, 8'h00);
        check("rst_flags", {overflow, underflow, valid}, 3'b000);

        // Random traffic, addresses biased toward the stack region.
        for (int i = 0; i < 800; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hF8, 8'hFF))
                                            : 8'($urandom_range(0, 255));
            cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 40,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 8,
                  a, 8'($urandom_range(0, 255)));
        end
        do_idle();
        do_idle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
